// File: rtl/regfile_sequencer.sv
// regfile_sequencer: issues register-file reads for one instruction, holds the
// operands until the execute result arrives, then writes the result back.
// A debug dump mode streams x0..x31 out through read port 1.
module regfile_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_rs1,
  input  logic [4:0]      req_rs2,
  input  logic [4:0]      req_rd,
  input  logic            req_use_rs1,
  input  logic            req_use_rs2,
  input  logic            req_wb,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic            op_valid,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_data,
  output logic            done,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_wen,
  input  logic            dbg_req,
  output logic            dbg_valid,
  output logic [4:0]      dbg_idx,
  output logic [XLEN-1:0] dbg_data,
  output logic            dbg_last
);

  localparam int unsigned AW = 5;
  localparam int unsigned SW = 3;

  localparam logic [SW-1:0] IDLE = 3'd0;
  localparam logic [SW-1:0] READ = 3'd1;
  localparam logic [SW-1:0] OPS  = 3'd2;
  localparam logic [SW-1:0] WB   = 3'd3;
  localparam logic [SW-1:0] DUMP = 3'd4;

  localparam logic [AW-1:0] LAST_IDX = AW'(31);

  logic [SW-1:0]   state_q, state_d;
  logic [AW-1:0]   rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic            use_rs1_q, use_rs1_d, use_rs2_q, use_rs2_d;
  logic            wb_q, wb_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] op_a_d, op_b_d;

  logic            req_ready_d, op_valid_d, done_d, rd_wen_d;
  logic [AW-1:0]   rs1_addr_d, rs2_addr_d, rd_addr_d, dbg_idx_d;
  logic [XLEN-1:0] rd_data_d;
  logic            dbg_valid_d, dbg_last_d;

  // Dump data is the live read-port value, zero outside dump beats.
  assign dbg_data = dbg_valid ? rs1_data : '0;

  // State, latched fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      use_rs1_q <= 1'b0;
      use_rs2_q <= 1'b0;
      wb_q      <= 1'b0;
      res_q     <= '0;
      idx_q     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      req_ready <= 1'b0;
      op_valid  <= 1'b0;
      done      <= 1'b0;
      rs1_addr  <= '0;
      rs2_addr  <= '0;
      rd_addr   <= '0;
      rd_data   <= '0;
      rd_wen    <= 1'b0;
      dbg_valid <= 1'b0;
      dbg_idx   <= '0;
      dbg_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      use_rs1_q <= use_rs1_d;
      use_rs2_q <= use_rs2_d;
      wb_q      <= wb_d;
      res_q     <= res_d;
      idx_q     <= idx_d;
      op_a      <= op_a_d;
      op_b      <= op_b_d;
      req_ready <= req_ready_d;
      op_valid  <= op_valid_d;
      done      <= done_d;
      rs1_addr  <= rs1_addr_d;
      rs2_addr  <= rs2_addr_d;
      rd_addr   <= rd_addr_d;
      rd_data   <= rd_data_d;
      rd_wen    <= rd_wen_d;
      dbg_valid <= dbg_valid_d;
      dbg_idx   <= dbg_idx_d;
      dbg_last  <= dbg_last_d;
    end
  end

  // Next state, next latched fields, and next-cycle outputs decoded from the next state.
  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    use_rs1_d   = use_rs1_q;
    use_rs2_d   = use_rs2_q;
    wb_d        = wb_q;
    res_d       = res_q;
    idx_d       = idx_q;
    op_a_d      = op_a;
    op_b_d      = op_b;
    req_ready_d = 1'b0;
    op_valid_d  = 1'b0;
    done_d      = 1'b0;
    rs1_addr_d  = '0;
    rs2_addr_d  = '0;
    rd_addr_d   = '0;
    rd_data_d   = '0;
    rd_wen_d    = 1'b0;
    dbg_valid_d = 1'b0;
    dbg_idx_d   = '0;
    dbg_last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // req_ready mirrors IDLE except in the first cycle after reset.
        if (req_ready && req_valid) begin
          rs1_d     = req_rs1;
          rs2_d     = req_rs2;
          rd_d      = req_rd;
          use_rs1_d = req_use_rs1;
          use_rs2_d = req_use_rs2;
          wb_d      = req_wb;
          state_d   = READ;
        end else if (req_ready && dbg_req) begin
          idx_d   = '0;
          state_d = DUMP;
        end
      end
      READ: begin
        op_a_d  = use_rs1_q ? rs1_data : '0;
        op_b_d  = use_rs2_q ? rs2_data : '0;
        state_d = OPS;
      end
      OPS: begin
        if (res_valid) begin
          res_d   = res_data;
          state_d = WB;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      DUMP: begin
        // Exit after the x31 beat; the counter never wraps.
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      IDLE: req_ready_d = 1'b1;
      READ: begin
        rs1_addr_d = use_rs1_d ? rs1_d : '0;
        rs2_addr_d = use_rs2_d ? rs2_d : '0;
      end
      OPS: op_valid_d = 1'b1;
      WB: begin
        done_d    = 1'b1;
        rd_addr_d = rd_d;
        rd_data_d = res_d;
        rd_wen_d  = wb_d && (rd_d != '0);
      end
      DUMP: begin
        rs1_addr_d  = idx_d;
        dbg_valid_d = 1'b1;
        dbg_idx_d   = idx_d;
        dbg_last_d  = (idx_d == LAST_IDX);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file, table of instruction
// vectors with hand-computed operands, then dump and reset corner sequences.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic        req_use_rs1, req_use_rs2, req_wb;
  logic [31:0] op_a, op_b;
  logic        op_valid;
  logic        res_valid;
  logic [31:0] res_data;
  logic        done;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, rd_data;
  logic        rd_wen;
  logic        dbg_req, dbg_valid, dbg_last;
  logic [4:0]  dbg_idx;
  logic [31:0] dbg_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_use_rs1(req_use_rs1), .req_use_rs2(req_use_rs2), .req_wb(req_wb),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .res_valid(res_valid), .res_data(res_data), .done(done),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_wen(rd_wen),
    .dbg_req(dbg_req), .dbg_valid(dbg_valid), .dbg_idx(dbg_idx),
    .dbg_data(dbg_data), .dbg_last(dbg_last)
  );

  // Register file: combinational reads, x0 hardwired to zero.
  logic [31:0] mem [32] = '{default: 32'h0};
  assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : mem[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : mem[rs2_addr];
  always @(posedge clk) if (rd_wen && rd_addr != 5'd0) mem[rd_addr] <= rd_data;

  // Any write to x0, or to x11 (only used by the abandoned instruction), is an error.
  always @(negedge clk) begin
    if (rd_wen) begin
      n_vec++;
      if (rd_addr == 5'd0 || rd_addr == 5'd11) begin
        n_err++;
        $display("FAIL illegal_write: rd_addr=%0d rd_data=%h", rd_addr, rd_data);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, wb;
    logic [31:0] res;
    int          delay;
    logic        read_pulse;
    logic [31:0] ea, eb;
    logic        ewen;
  } vec_t;

  vec_t vecs [6];

  // Expected register contents after all vectors have retired.
  function automatic logic [31:0] exp_reg(input int i);
    case (i)
      5:       return 32'h1234_5678;
      6:       return 32'hFFFF_0000;
      9:       return 32'h0BAD_F00D;
      10:      return 32'h5555_AAAA;
      default: return 32'h0;
    endcase
  endfunction

  // Runs one instruction; entered and left at a negedge in IDLE.
  task automatic run_vec(input vec_t v, input int k);
    string tag;
    tag = $sformatf("v%0d", k);
    chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_rs1 = v.rs1; req_rs2 = v.rs2; req_rd = v.rd;
    req_use_rs1 = v.u1; req_use_rs2 = v.u2; req_wb = v.wb;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.read_pulse) res_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_read_state"}, {29'd0, req_ready, op_valid, done}, 32'd0);
    chk({tag, "_rs1_addr"}, 32'(rs1_addr), v.u1 ? 32'(v.rs1) : 32'd0);
    chk({tag, "_rs2_addr"}, 32'(rs2_addr), v.u2 ? 32'(v.rs2) : 32'd0);
    @(posedge clk); #1;
    res_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_op_valid"}, 32'(op_valid), 32'd1);
    chk({tag, "_op_a"}, op_a, v.ea);
    chk({tag, "_op_b"}, op_b, v.eb);
    for (int d = 0; d < v.delay; d++) begin
      @(posedge clk); @(negedge clk);
      chk({tag, "_ops_wait"}, {29'd0, op_valid, done, req_ready}, 32'd4);
    end
    res_data  = v.res;
    res_valid = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    res_data  = 32'h0;
    @(negedge clk);
    chk({tag, "_wb_done"}, {29'd0, done, req_ready, op_valid}, 32'd4);
    chk({tag, "_wb_wen"}, 32'(rd_wen), 32'(v.ewen));
    if (v.ewen) begin
      chk({tag, "_wb_addr"}, 32'(rd_addr), 32'(v.rd));
      chk({tag, "_wb_data"}, rd_data, v.res);
    end
    @(posedge clk); @(negedge clk);
    chk({tag, "_after_wb"}, {29'd0, done, rd_wen, req_ready}, 32'd1);
  endtask

  initial begin
    bit found;
    vecs[0] = '{5'd0, 5'd0, 5'd5,  1'b0, 1'b0, 1'b1, 32'h1234_5678, 0, 1'b0, 32'h0,         32'h0,         1'b1};
    vecs[1] = '{5'd0, 5'd0, 5'd6,  1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 1, 1'b0, 32'h0,         32'h0,         1'b1};
    vecs[2] = '{5'd5, 5'd6, 5'd7,  1'b1, 1'b1, 1'b0, 32'h0000_AAAA, 3, 1'b0, 32'h1234_5678, 32'hFFFF_0000, 1'b0};
    vecs[3] = '{5'd5, 5'd6, 5'd0,  1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h1234_5678, 32'h0,         1'b0};
    vecs[4] = '{5'd0, 5'd0, 5'd9,  1'b1, 1'b1, 1'b1, 32'h0BAD_F00D, 7, 1'b1, 32'h0,         32'h0,         1'b1};
    vecs[5] = '{5'd9, 5'd5, 5'd10, 1'b1, 1'b1, 1'b1, 32'h5555_AAAA, 2, 1'b0, 32'h0BAD_F00D, 32'h1234_5678, 1'b1};

    rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    req_use_rs1 = 1'b0; req_use_rs2 = 1'b0; req_wb = 1'b0;
    res_valid = 1'b0; res_data = '0; dbg_req = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {26'd0, req_ready, op_valid, done, rd_wen, dbg_valid, dbg_last}, 32'd0);
    chk("reset_op_a", op_a, 32'h0);
    chk("reset_addrs", {17'd0, rs1_addr, rs2_addr, rd_addr}, 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // Register dump; dbg_req held into the dump must not restart it.
    dbg_req = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i == 20) dbg_req = 1'b0;
      chk($sformatf("dump_beat%0d", i),
          {24'd0, dbg_valid, dbg_last, req_ready, dbg_idx},
          {24'd0, 1'b1, (i == 31), 1'b0, 5'(i)});
      chk($sformatf("dump_data%0d", i), dbg_data, exp_reg(i));
      chk($sformatf("dump_rs2_%0d", i), 32'(rs2_addr), 32'd0);
    end
    @(posedge clk); @(negedge clk);
    chk("dump_end", {30'd0, dbg_valid, req_ready}, 32'd1);

    // Reset while waiting in OPS abandons the write to x11.
    req_rs1 = 5'd5; req_use_rs1 = 1'b1; req_use_rs2 = 1'b0; req_rd = 5'd11; req_wb = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("ops_before_rst", 32'(op_valid), 32'd1);
    rst = 1'b1; res_valid = 1'b1; res_data = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    chk("rst_ops_outputs", {27'd0, req_ready, op_valid, done, rd_wen, dbg_valid}, 32'd0);
    chk("rst_ops_op_a", op_a, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1; res_valid = 1'b0;
    @(negedge clk);
    chk("rst_ops_ready", {29'd0, req_ready, rd_wen, done}, 32'd4);
    @(posedge clk); @(negedge clk);
    chk("rst_ops_no_wb", {30'd0, rd_wen, done}, 32'd0);

    // Reset in the middle of a dump.
    dbg_req = 1'b1;
    @(posedge clk); #1; dbg_req = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (dbg_valid && dbg_idx == 5'd10) found = 1'b1;
    end
    chk("dump_reach_idx10", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_dump_outputs", {20'd0, dbg_valid, dbg_last, req_ready, dbg_idx, rs1_addr}, 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_dump_ready", {30'd0, req_ready, dbg_valid}, 32'd2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dump_halted", {30'd0, req_ready, dbg_valid}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
